// File: rtl/interrupt_vector_sequencer_if.sv
// rtl/interrupt_vector_sequencer_if.sv - address/data-path control bundle driven by the interrupt vector sequencer
interface interrupt_vector_sequencer_if;
  logic       PCL_ADL;
  logic       S_ADL;
  logic       ADL_FF;
  logic       ADH_FF;
  logic       ADH_01;
  logic       Zero_ADL0;
  logic       Zero_ADL1;
  logic       Zero_ADL2;
  logic       r_w_n;
  logic [1:0] push_sel;
  logic       b_flag;
  logic       sp_dec;
  logic       set_i;
  logic       pcl_load;
  logic       pch_load;

  modport master (
    output PCL_ADL, S_ADL, ADL_FF, ADH_FF, ADH_01,
    output Zero_ADL0, Zero_ADL1, Zero_ADL2,
    output r_w_n, push_sel, b_flag, sp_dec, set_i, pcl_load, pch_load
  );

  modport slave (
    input PCL_ADL, S_ADL, ADL_FF, ADH_FF, ADH_01,
    input Zero_ADL0, Zero_ADL1, Zero_ADL2,
    input r_w_n, push_sel, b_flag, sp_dec, set_i, pcl_load, pch_load
  );
endinterface

// File: rtl/interrupt_vector_sequencer.sv
// rtl/interrupt_vector_sequencer.sv - 6502 BRK/IRQ/NMI/RESET T1..T6 sequencer (optional NMI_HIJACK_EN)
module interrupt_vector_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ready,
  input  logic       sync,
  input  logic       brk_op,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       i_flag,
  output logic       seq_busy,
  output logic [2:0] seq_step,
  output logic       force_brk,
  output logic       pc_inc,
  output logic       seq_done,
  interrupt_vector_sequencer_if.master adr
);

  typedef enum logic [2:0] {
    ST_RST, ST_IDLE, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6
  } state_t;

  typedef enum logic [1:0] {K_RESET, K_NMI, K_IRQ, K_BRK} kind_t;

  state_t state, state_nx;
  kind_t  kind, kind_nx;
  logic   nmi_prev, nmi_pend, nmi_fall, nmi_clr;
  logic   hw_int, read_cyc, stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RST;
      kind     <= K_RESET;
      nmi_prev <= 1'b1;
      nmi_pend <= 1'b0;
    end else begin
      state    <= state_nx;
      kind     <= kind_nx;
      nmi_prev <= nmi_n;
      // a new edge in the clearing cycle must not be lost
      nmi_pend <= nmi_fall | (nmi_pend & ~nmi_clr);
    end
  end

  always_comb begin
    nmi_fall = nmi_prev & ~nmi_n;
    hw_int   = nmi_pend | (~irq_n & ~i_flag);
    case (state)
      ST_T1, ST_T5, ST_T6: read_cyc = 1'b1;
      ST_T2, ST_T3, ST_T4: read_cyc = (kind == K_RESET);
      default:             read_cyc = 1'b0;
    endcase
    stall = read_cyc & ~ready;
  end

  always_comb begin
    state_nx  = state;
    kind_nx   = kind;
    nmi_clr   = 1'b0;
    force_brk = 1'b0;
    case (state)
      ST_RST: begin
        state_nx = ST_T1;
        kind_nx  = K_RESET;
      end
      ST_IDLE: begin
        if (sync && ready && hw_int) begin
          force_brk = 1'b1;
          state_nx  = ST_T1;
          kind_nx   = nmi_pend ? K_NMI : K_IRQ;
        end else if (brk_op) begin
          state_nx = ST_T1;
          kind_nx  = K_BRK;
        end
      end
      ST_T1: if (!stall) state_nx = ST_T2;
      ST_T2: if (!stall) state_nx = ST_T3;
      ST_T3: if (!stall) state_nx = ST_T4;
      ST_T4: begin
        if (!stall) begin
          state_nx = ST_T5;
`ifdef NMI_HIJACK_EN
          if (nmi_pend && (kind == K_IRQ || kind == K_BRK))
            kind_nx = K_NMI;
`endif
        end
      end
      ST_T5: if (!stall) state_nx = ST_T6;
      ST_T6: begin
        if (!stall) begin
          state_nx = ST_IDLE;
          nmi_clr  = (kind == K_NMI);
        end
      end
      default: state_nx = ST_RST;
    endcase
  end

  always_comb begin
    seq_busy      = (state != ST_IDLE);
    seq_step      = 3'd0;
    pc_inc        = 1'b0;
    seq_done      = 1'b0;
    adr.PCL_ADL   = 1'b0;
    adr.S_ADL     = 1'b0;
    adr.ADL_FF    = 1'b0;
    adr.ADH_FF    = 1'b0;
    adr.ADH_01    = 1'b0;
    adr.Zero_ADL0 = 1'b0;
    adr.Zero_ADL1 = 1'b0;
    adr.Zero_ADL2 = 1'b0;
    adr.r_w_n     = 1'b1;
    adr.push_sel  = 2'b00;
    adr.b_flag    = 1'b0;
    adr.sp_dec    = 1'b0;
    adr.set_i     = 1'b0;
    adr.pcl_load  = 1'b0;
    adr.pch_load  = 1'b0;
    case (state)
      ST_T1: begin
        seq_step    = 3'd1;
        adr.PCL_ADL = 1'b1;
        pc_inc      = (kind == K_BRK);
      end
      ST_T2, ST_T3, ST_T4: begin
        adr.ADH_01 = 1'b1;
        adr.S_ADL  = 1'b1;
        adr.sp_dec = 1'b1;
        // RESET walks the stack with reads so memory is left untouched
        adr.r_w_n  = (kind == K_RESET);
        if (state == ST_T2) begin
          seq_step     = 3'd2;
          adr.push_sel = 2'b00;
        end else if (state == ST_T3) begin
          seq_step     = 3'd3;
          adr.push_sel = 2'b01;
        end else begin
          seq_step     = 3'd4;
          adr.push_sel = 2'b10;
          adr.b_flag   = (kind == K_BRK);
        end
      end
      ST_T5: begin
        seq_step      = 3'd5;
        adr.ADL_FF    = 1'b1;
        adr.ADH_FF    = 1'b1;
        adr.Zero_ADL0 = 1'b1;
        adr.Zero_ADL1 = (kind == K_RESET);
        adr.Zero_ADL2 = (kind == K_NMI);
        adr.pcl_load  = 1'b1;
        adr.set_i     = 1'b1;
      end
      ST_T6: begin
        seq_step      = 3'd6;
        adr.ADL_FF    = 1'b1;
        adr.ADH_FF    = 1'b1;
        adr.Zero_ADL1 = (kind == K_RESET);
        adr.Zero_ADL2 = (kind == K_NMI);
        adr.pch_load  = 1'b1;
        seq_done      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_interrupt_vector_sequencer.sv
// tb/tb_interrupt_vector_sequencer.sv - table-driven bench for interrupt_vector_sequencer
module tb_interrupt_vector_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ready, sync, brk_op, nmi_n, irq_n, i_flag;
  logic       seq_busy, force_brk, pc_inc, seq_done;
  logic [2:0] seq_step;

  interrupt_vector_sequencer_if bus();

  interrupt_vector_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ready     (ready),
    .sync      (sync),
    .brk_op    (brk_op),
    .nmi_n     (nmi_n),
    .irq_n     (irq_n),
    .i_flag    (i_flag),
    .seq_busy  (seq_busy),
    .seq_step  (seq_step),
    .force_brk (force_brk),
    .pc_inc    (pc_inc),
    .seq_done  (seq_done),
    .adr       (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, ready, sync, brk_op, nmi_n, irq_n, i_flag;
    logic [22:0] exp;
  } row_t;

  row_t rows[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vidx  = 0;

  // {busy, step, force_brk, r_w_n, {PCL_ADL,S_ADL,ADL_FF,ADH_FF,ADH_01}, {Z2,Z1,Z0}, push_sel,
  //  {pc_inc,b_flag,sp_dec,set_i,pcl_load,pch_load,seq_done}}
  function automatic logic [22:0] pk(input logic busy, input logic [2:0] step, input logic fb,
                                     input logic rw, input logic [4:0] sel, input logic [2:0] z,
                                     input logic [1:0] ps, input logic [6:0] misc);
    return {busy, step, fb, rw, sel, z, ps, misc};
  endfunction

  function automatic logic [22:0] actual();
    return pk(seq_busy, seq_step, force_brk, bus.r_w_n,
              {bus.PCL_ADL, bus.S_ADL, bus.ADL_FF, bus.ADH_FF, bus.ADH_01},
              {bus.Zero_ADL2, bus.Zero_ADL1, bus.Zero_ADL0}, bus.push_sel,
              {pc_inc, bus.b_flag, bus.sp_dec, bus.set_i, bus.pcl_load, bus.pch_load, seq_done});
  endfunction

  task automatic check(input string tag, input logic [22:0] exp);
    logic [22:0] act;
    act = actual();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %06h expected %06h", tag, vidx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic rdy, input logic s, input logic b,
                     input logic n, input logic i, input logic f, input logic [22:0] e);
    row_t t;
    t.rst_n = r; t.ready = rdy; t.sync = s; t.brk_op = b;
    t.nmi_n = n; t.irq_n = i; t.i_flag = f; t.exp = e;
    rows.push_back(t);
  endtask

  task automatic run_rows(input string tag);
    foreach (rows[k]) begin
      @(negedge clk);
      rst_n  = rows[k].rst_n;
      ready  = rows[k].ready;
      sync   = rows[k].sync;
      brk_op = rows[k].brk_op;
      nmi_n  = rows[k].nmi_n;
      irq_n  = rows[k].irq_n;
      i_flag = rows[k].i_flag;
      #1 check(tag, rows[k].exp);
      vidx++;
    end
    rows.delete();
  endtask

  logic [22:0] e_rst, e_idle, e_fb, e_t1, e_t1b;
  logic [22:0] e_t2w, e_t3w, e_t4w, e_t4wb, e_t2r, e_t3r, e_t4r;
  logic [22:0] e_t5_fffe, e_t5_fffa, e_t5_fffc, e_t6_ffff, e_t6_fffb, e_t6_fffd;

  initial begin
    ready = 1'b1; sync = 1'b0; brk_op = 1'b0; nmi_n = 1'b1; irq_n = 1'b1; i_flag = 1'b0;
    #1 rst_n = 1'b0;

    e_rst     = pk(1'b1, 3'd0, 1'b0, 1'b1, 5'b00000, 3'b000, 2'b00, 7'b0000000);
    e_idle    = pk(1'b0, 3'd0, 1'b0, 1'b1, 5'b00000, 3'b000, 2'b00, 7'b0000000);
    e_fb      = pk(1'b0, 3'd0, 1'b1, 1'b1, 5'b00000, 3'b000, 2'b00, 7'b0000000);
    e_t1      = pk(1'b1, 3'd1, 1'b0, 1'b1, 5'b10000, 3'b000, 2'b00, 7'b0000000);
    e_t1b     = pk(1'b1, 3'd1, 1'b0, 1'b1, 5'b10000, 3'b000, 2'b00, 7'b1000000);
    e_t2w     = pk(1'b1, 3'd2, 1'b0, 1'b0, 5'b01001, 3'b000, 2'b00, 7'b0010000);
    e_t3w     = pk(1'b1, 3'd3, 1'b0, 1'b0, 5'b01001, 3'b000, 2'b01, 7'b0010000);
    e_t4w     = pk(1'b1, 3'd4, 1'b0, 1'b0, 5'b01001, 3'b000, 2'b10, 7'b0010000);
    e_t4wb    = pk(1'b1, 3'd4, 1'b0, 1'b0, 5'b01001, 3'b000, 2'b10, 7'b0110000);
    e_t2r     = pk(1'b1, 3'd2, 1'b0, 1'b1, 5'b01001, 3'b000, 2'b00, 7'b0010000);
    e_t3r     = pk(1'b1, 3'd3, 1'b0, 1'b1, 5'b01001, 3'b000, 2'b01, 7'b0010000);
    e_t4r     = pk(1'b1, 3'd4, 1'b0, 1'b1, 5'b01001, 3'b000, 2'b10, 7'b0010000);
    e_t5_fffe = pk(1'b1, 3'd5, 1'b0, 1'b1, 5'b00110, 3'b001, 2'b00, 7'b0001100);
    e_t5_fffa = pk(1'b1, 3'd5, 1'b0, 1'b1, 5'b00110, 3'b101, 2'b00, 7'b0001100);
    e_t5_fffc = pk(1'b1, 3'd5, 1'b0, 1'b1, 5'b00110, 3'b011, 2'b00, 7'b0001100);
    e_t6_ffff = pk(1'b1, 3'd6, 1'b0, 1'b1, 5'b00110, 3'b000, 2'b00, 7'b0000011);
    e_t6_fffb = pk(1'b1, 3'd6, 1'b0, 1'b1, 5'b00110, 3'b100, 2'b00, 7'b0000011);
    e_t6_fffd = pk(1'b1, 3'd6, 1'b0, 1'b1, 5'b00110, 3'b010, 2'b00, 7'b0000011);

    // reset release -> RESET sequence with reads only
    add(0,1,0,0,1,1,0,e_rst);     add(0,1,0,0,1,1,0,e_rst);   add(1,1,0,0,1,1,0,e_rst);
    add(1,1,0,0,1,1,0,e_t1);      add(1,1,0,0,1,1,0,e_t2r);   add(1,1,0,0,1,1,0,e_t3r);
    add(1,1,0,0,1,1,0,e_t4r);     add(1,1,0,0,1,1,0,e_t5_fffc);
    add(1,1,0,0,1,1,0,e_t6_fffd); add(1,1,0,0,1,1,0,e_idle);
    // IRQ taken; IRQ held low while busy is ignored
    add(1,1,1,0,1,0,0,e_fb);      add(1,1,0,0,1,0,0,e_t1);    add(1,1,0,0,1,0,0,e_t2w);
    add(1,1,0,0,1,0,0,e_t3w);     add(1,1,0,0,1,0,0,e_t4w);   add(1,1,0,0,1,0,0,e_t5_fffe);
    add(1,1,0,0,1,0,0,e_t6_ffff);
    add(1,1,1,0,1,0,1,e_idle);    add(1,1,0,0,1,0,0,e_idle);  add(1,1,1,0,1,1,0,e_idle);
    // ready low at sync blocks entry; read stalls in T1/T5, write T3 ignores ready
    add(1,0,1,0,1,0,0,e_idle);    add(1,1,1,0,1,0,0,e_fb);
    add(1,0,0,0,1,1,0,e_t1);      add(1,1,0,0,1,1,0,e_t1);    add(1,1,0,0,1,1,0,e_t2w);
    add(1,0,0,0,1,1,0,e_t3w);     add(1,1,0,0,1,1,0,e_t4w);
    add(1,0,0,0,1,1,0,e_t5_fffe); add(1,0,0,0,1,1,0,e_t5_fffe); add(1,0,0,0,1,1,0,e_t5_fffe);
    add(1,1,0,0,1,1,0,e_t5_fffe); add(1,1,0,0,1,1,0,e_t6_ffff); add(1,1,0,0,1,1,0,e_idle);
    // one-cycle NMI pulse
    add(1,1,0,0,0,1,0,e_idle);    add(1,1,1,0,1,1,0,e_fb);    add(1,1,0,0,1,1,0,e_t1);
    add(1,1,0,0,1,1,0,e_t2w);     add(1,1,0,0,1,1,0,e_t3w);   add(1,1,0,0,1,1,0,e_t4w);
    add(1,1,0,0,1,1,0,e_t5_fffa); add(1,1,0,0,1,1,0,e_t6_fffb); add(1,1,1,0,1,1,0,e_idle);
    // NMI held low: one sequence only
    add(1,1,0,0,0,1,0,e_idle);    add(1,1,1,0,0,1,0,e_fb);    add(1,1,0,0,0,1,0,e_t1);
    add(1,1,0,0,0,1,0,e_t2w);     add(1,1,0,0,0,1,0,e_t3w);   add(1,1,0,0,0,1,0,e_t4w);
    add(1,1,0,0,0,1,0,e_t5_fffa); add(1,1,0,0,0,1,0,e_t6_fffb);
    add(1,1,1,0,0,1,0,e_idle);    add(1,1,1,0,1,1,0,e_idle);
    // BRK opcode
    add(1,1,0,1,1,1,0,e_idle);    add(1,1,0,0,1,1,0,e_t1b);   add(1,1,0,0,1,1,0,e_t2w);
    add(1,1,0,0,1,1,0,e_t3w);     add(1,1,0,0,1,1,0,e_t4wb);  add(1,1,0,0,1,1,0,e_t5_fffe);
    add(1,1,0,0,1,1,0,e_t6_ffff); add(1,1,0,0,1,1,0,e_idle);
    // hardware interrupt at sync beats brk_op
    add(1,1,1,1,1,0,0,e_fb);      add(1,1,0,0,1,1,0,e_t1);    add(1,1,0,0,1,1,0,e_t2w);
    add(1,1,0,0,1,1,0,e_t3w);     add(1,1,0,0,1,1,0,e_t4w);   add(1,1,0,0,1,1,0,e_t5_fffe);
    add(1,1,0,0,1,1,0,e_t6_ffff); add(1,1,0,0,1,1,0,e_idle);
    run_rows("vec");

    // BRK with NMI falling during T3
    add(1,1,0,1,1,1,0,e_idle);    add(1,1,0,0,1,1,0,e_t1b);   add(1,1,0,0,1,1,0,e_t2w);
    add(1,1,0,0,0,1,0,e_t3w);     add(1,1,0,0,1,1,0,e_t4wb);
`ifdef NMI_HIJACK_EN
    add(1,1,0,0,1,1,0,e_t5_fffa); add(1,1,0,0,1,1,0,e_t6_fffb); add(1,1,1,0,1,1,0,e_idle);
`else
    add(1,1,0,0,1,1,0,e_t5_fffe); add(1,1,0,0,1,1,0,e_t6_ffff); add(1,1,1,0,1,1,0,e_fb);
    add(1,1,0,0,1,1,0,e_t1);      add(1,1,0,0,1,1,0,e_t2w);   add(1,1,0,0,1,1,0,e_t3w);
    add(1,1,0,0,1,1,0,e_t4w);     add(1,1,0,0,1,1,0,e_t5_fffa); add(1,1,0,0,1,1,0,e_t6_fffb);
    add(1,1,1,0,1,1,0,e_idle);
`endif
    run_rows("hijack");

    // async reset in T4 of an IRQ with an NMI pending
    add(1,1,1,0,1,0,0,e_fb);      add(1,1,0,0,1,1,0,e_t1);    add(1,1,0,0,0,1,0,e_t2w);
    add(1,1,0,0,1,1,0,e_t3w);
    run_rows("rst_mid");
    @(negedge clk);
    #1 check("rst_mid_t4", e_t4w);
    #1 rst_n = 1'b0;
    #1 check("rst_mid_async", e_rst);
    add(0,1,0,0,1,1,0,e_rst);     add(1,1,0,0,1,1,0,e_rst);   add(1,1,0,0,1,1,0,e_t1);
    add(1,1,0,0,1,1,0,e_t2r);     add(1,1,0,0,1,1,0,e_t3r);   add(1,1,0,0,1,1,0,e_t4r);
    add(1,1,0,0,1,1,0,e_t5_fffc); add(1,1,0,0,1,1,0,e_t6_fffd); add(1,1,1,0,1,1,0,e_idle);
    add(1,1,0,0,1,1,0,e_idle);
    run_rows("rst_seq");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
